ras_rollback_ctrl: RTL and testbench

RAS_ROLLBACK_CTRL -- requirements
Module: ras_rollback_ctrl

---
 rtl/pqr5_core_pkg.sv | 25 ++
 rtl/ras_rollback_ctrl_if.sv | 15 +
 rtl/ras_rollback_ctrl_snap_stage.sv | 30 +++
 rtl/ras_rollback_ctrl.sv | 112 +++++++++++
 tb/tb_ras_rollback_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pqr5_core_pkg.sv
// rtl/pqr5_core_pkg.sv - shared types and constants for the RAS rollback controller
`ifndef RAS_DPT
`define RAS_DPT 8
`endif

package pqr5_core_pkg;

  localparam int RAS_PTRW  = $clog2(`RAS_DPT);
  localparam int RBK_CNT_W = 16;

  // One pipeline-stage record of return-address-stack state
  typedef struct packed {
    logic                valid;
    logic                is_call;
    logic                ret_taken;
    logic [RAS_PTRW-1:0] snap_ptr;
    logic                snap_full;
  } ras_snap_t;

  // Saturating increment: sticks at all-ones instead of wrapping
  function automatic logic [RBK_CNT_W-1:0] sat_inc(input logic [RBK_CNT_W-1:0] v);
    return (&v) ? v : v + RBK_CNT_W'(1);
  endfunction

endpackage

// File: rtl/ras_rollback_ctrl_if.sv
// rtl/ras_rollback_ctrl_if.sv - rollback request bundle towards the call stack
interface ras_rollback_ctrl_if #(
  parameter int PTRW = 3
);
  import pqr5_core_pkg::*;

  logic                 rbk_en;
  logic [PTRW-1:0]      rbk_ptr;
  logic                 rbk_full;
  logic                 rbk_incr_ptr;
  logic [RBK_CNT_W-1:0] rbk_cnt;

  modport master (output rbk_en, output rbk_ptr, output rbk_full, output rbk_incr_ptr, output rbk_cnt);
  modport slave  (input  rbk_en, input  rbk_ptr, input  rbk_full, input  rbk_incr_ptr, input  rbk_cnt);
endinterface

// File: rtl/ras_rollback_ctrl_snap_stage.sv
// rtl/ras_rollback_ctrl_snap_stage.sv - one stall/flush-able RAS snapshot pipeline register
module ras_snap_stage
  import pqr5_core_pkg::*;
(
  input  logic      clk,
  input  logic      aresetn,
  input  logic      i_en,
  input  logic      i_clr,
  input  ras_snap_t i_d,
  output ras_snap_t o_q
);

  ras_snap_t r_q;

  // Flush beats stall; an entry captured invalid never carries call/ret flags
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q           <= i_d;
      r_q.is_call   <= i_d.valid & i_d.is_call;
      r_q.ret_taken <= i_d.valid & i_d.ret_taken;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ras_rollback_ctrl.sv
// rtl/ras_rollback_ctrl.sv - tracks RAS snapshots through DU/EX and issues call-stack rollbacks
`ifndef RAS_DPT
`define RAS_DPT 8
`endif

module ras_rollback_ctrl
  import pqr5_core_pkg::*;
#(
  parameter  int ST_DPT  = `RAS_DPT,
  localparam int ST_PTRW = $clog2(ST_DPT)
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 i_stall,
  input  logic                 i_fu_valid,
  input  logic                 i_fu_is_call,
  input  logic                 i_fu_ret_taken,
  input  logic [ST_PTRW-1:0]   i_fu_snap_ptr,
  input  logic                 i_fu_snap_full,
  input  logic                 i_ras_flush,
  input  logic                 i_exu_flush,
  output logic                 o_is_call_fu,
  output logic                 o_is_call_du,
  output logic                 o_is_ret_taken_du,
  output logic                 o_rbk_en,
  output logic [ST_PTRW-1:0]   o_rbk_ptr,
  output logic                 o_rbk_full,
  output logic                 o_rbk_incr_ptr,
  output logic [RBK_CNT_W-1:0] o_rbk_cnt,
  ras_rollback_ctrl_if.master  m_rbk
);

  ras_snap_t            w_du_d;
  ras_snap_t            w_du_q;
  ras_snap_t            w_ex_q;
  logic                 w_stage_en;
  logic                 w_rbk_fire;
  logic                 w_unused_ex_ret;

  logic                 r_rbk_en;
  logic [ST_PTRW-1:0]   r_rbk_ptr;
  logic                 r_rbk_full;
  logic                 r_rbk_incr_ptr;
  logic [RBK_CNT_W-1:0] r_rbk_cnt;

  // A RAS flush kills the instruction leaving FU before it reaches DU
  assign w_du_d.valid     = i_fu_valid & ~i_ras_flush;
  assign w_du_d.is_call   = i_fu_is_call;
  assign w_du_d.ret_taken = i_fu_ret_taken;
  assign w_du_d.snap_ptr  = RAS_PTRW'(i_fu_snap_ptr);
  assign w_du_d.snap_full = i_fu_snap_full;

  assign w_stage_en = ~i_stall;

  ras_snap_stage u_du (
    .clk     (clk),
    .aresetn (aresetn),
    .i_en    (w_stage_en),
    .i_clr   (i_exu_flush),
    .i_d     (w_du_d),
    .o_q     (w_du_q)
  );

  ras_snap_stage u_ex (
    .clk     (clk),
    .aresetn (aresetn),
    .i_en    (w_stage_en),
    .i_clr   (i_exu_flush),
    .i_d     (w_du_q),
    .o_q     (w_ex_q)
  );

  // Only a live instruction in EX can be the source of a rollback
  assign w_rbk_fire      = i_exu_flush & w_ex_q.valid;
  assign w_unused_ex_ret = w_ex_q.ret_taken;

  // Register the rollback request; payload holds between pulses
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_rbk_en       <= 1'b0;
      r_rbk_ptr      <= '0;
      r_rbk_full     <= 1'b0;
      r_rbk_incr_ptr <= 1'b0;
      r_rbk_cnt      <= '0;
    end else begin
      r_rbk_en <= w_rbk_fire;
      if (w_rbk_fire) begin
        r_rbk_ptr      <= ST_PTRW'(w_ex_q.snap_ptr);
        r_rbk_full     <= w_ex_q.snap_full;
        r_rbk_incr_ptr <= w_ex_q.is_call;
        r_rbk_cnt      <= sat_inc(r_rbk_cnt);
      end
    end
  end

  assign o_is_call_fu      = i_fu_valid & i_fu_is_call;
  assign o_is_call_du      = w_du_q.valid & w_du_q.is_call;
  assign o_is_ret_taken_du = w_du_q.valid & w_du_q.ret_taken;

  assign o_rbk_en       = r_rbk_en;
  assign o_rbk_ptr      = r_rbk_ptr;
  assign o_rbk_full     = r_rbk_full;
  assign o_rbk_incr_ptr = r_rbk_incr_ptr;
  assign o_rbk_cnt      = r_rbk_cnt;

  assign m_rbk.rbk_en       = r_rbk_en;
  assign m_rbk.rbk_ptr      = r_rbk_ptr;
  assign m_rbk.rbk_full     = r_rbk_full;
  assign m_rbk.rbk_incr_ptr = r_rbk_incr_ptr;
  assign m_rbk.rbk_cnt      = r_rbk_cnt;

endmodule

// File: tb/tb_ras_rollback_ctrl.sv
// tb/tb_ras_rollback_ctrl.sv - self-checking bench for ras_rollback_ctrl
module tb_ras_rollback_ctrl;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        i_stall, i_fu_valid, i_fu_is_call, i_fu_ret_taken;
  logic [2:0]  i_fu_snap_ptr;
  logic        i_fu_snap_full, i_ras_flush, i_exu_flush;
  logic        o_is_call_fu, o_is_call_du, o_is_ret_taken_du;
  logic        o_rbk_en, o_rbk_full, o_rbk_incr_ptr;
  logic [2:0]  o_rbk_ptr;
  logic [15:0] o_rbk_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ras_rollback_ctrl_if #(.PTRW(3)) u_if ();

  ras_rollback_ctrl #(.ST_DPT(8)) dut (
    .clk               (clk),
    .aresetn           (aresetn),
    .i_stall           (i_stall),
    .i_fu_valid        (i_fu_valid),
    .i_fu_is_call      (i_fu_is_call),
    .i_fu_ret_taken    (i_fu_ret_taken),
    .i_fu_snap_ptr     (i_fu_snap_ptr),
    .i_fu_snap_full    (i_fu_snap_full),
    .i_ras_flush       (i_ras_flush),
    .i_exu_flush       (i_exu_flush),
    .o_is_call_fu      (o_is_call_fu),
    .o_is_call_du      (o_is_call_du),
    .o_is_ret_taken_du (o_is_ret_taken_du),
    .o_rbk_en          (o_rbk_en),
    .o_rbk_ptr         (o_rbk_ptr),
    .o_rbk_full        (o_rbk_full),
    .o_rbk_incr_ptr    (o_rbk_incr_ptr),
    .o_rbk_cnt         (o_rbk_cnt),
    .m_rbk             (u_if.master)
  );

  // Reference model: two-slot pipeline (0 = DU, 1 = EX) plus last rollback record
  typedef struct {
    bit v;
    bit c;
    bit r;
    int p;
    bit f;
  } ent_t;

  ent_t pipe[2];
  bit   m_en, m_full, m_incr;
  int   m_ptr, m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) pipe[i] = '{v: 0, c: 0, r: 0, p: 0, f: 0};
    m_en = 0; m_full = 0; m_incr = 0; m_ptr = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    bit fire;
    fire = i_exu_flush && pipe[1].v;
    m_en = fire;
    if (fire) begin
      m_ptr  = pipe[1].p;
      m_full = pipe[1].f;
      m_incr = pipe[1].c;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end
    if (i_exu_flush) begin
      for (int i = 0; i < 2; i++) pipe[i] = '{v: 0, c: 0, r: 0, p: 0, f: 0};
    end else if (!i_stall) begin
      pipe[1]   = pipe[0];
      pipe[0].v = i_fu_valid && !i_ras_flush;
      pipe[0].c = pipe[0].v && i_fu_is_call;
      pipe[0].r = pipe[0].v && i_fu_ret_taken;
      pipe[0].p = int'(i_fu_snap_ptr);
      pipe[0].f = i_fu_snap_full;
    end
  endtask

  task automatic check_outs();
    chk("is_call_du",     32'(o_is_call_du),      32'(pipe[0].v && pipe[0].c));
    chk("is_ret_du",      32'(o_is_ret_taken_du), 32'(pipe[0].v && pipe[0].r));
    chk("rbk_en",         32'(o_rbk_en),          32'(m_en));
    chk("rbk_ptr",        32'(o_rbk_ptr),         32'(m_ptr));
    chk("rbk_full",       32'(o_rbk_full),        32'(m_full));
    chk("rbk_incr",       32'(o_rbk_incr_ptr),    32'(m_incr));
    chk("rbk_cnt",        32'(o_rbk_cnt),         32'(m_cnt));
    chk("if_rbk_en",      32'(u_if.rbk_en),       32'(m_en));
    chk("if_rbk_ptr",     32'(u_if.rbk_ptr),      32'(m_ptr));
    chk("if_rbk_cnt",     32'(u_if.rbk_cnt),      32'(m_cnt));
  endtask

  task automatic drive(input bit v, input bit c, input bit r, input int p, input bit f,
                       input bit rf, input bit st, input bit xf);
    i_fu_valid     = v;
    i_fu_is_call   = c;
    i_fu_ret_taken = r;
    i_fu_snap_ptr  = 3'(p);
    i_fu_snap_full = f;
    i_ras_flush    = rf;
    i_stall        = st;
    i_exu_flush    = xf;
  endtask

  task automatic cycle();
    #1;
    chk("is_call_fu", 32'(o_is_call_fu), 32'(i_fu_valid && i_fu_is_call));
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
  endtask

  task automatic flush();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    cycle();
  endtask

  initial begin
    aresetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    chk("rst_en",   32'(o_rbk_en), 0);
    chk("rst_ptr",  32'(o_rbk_ptr), 0);
    chk("rst_full", 32'(o_rbk_full), 0);
    chk("rst_incr", 32'(o_rbk_incr_ptr), 0);
    chk("rst_cnt",  32'(o_rbk_cnt), 0);
    chk("rst_call_du", 32'(o_is_call_du), 0);
    chk("rst_ret_du",  32'(o_is_ret_taken_du), 0);
    @(negedge clk);
    aresetn = 1'b1;

    // CALL ptr 3 travels to EX, then rollback
    drive(1, 1, 0, 3, 0, 0, 0, 0); cycle();
    idle();
    flush();
    chk("call_rbk_en",   32'(o_rbk_en), 1);
    chk("call_rbk_ptr",  32'(o_rbk_ptr), 3);
    chk("call_rbk_full", 32'(o_rbk_full), 0);
    chk("call_rbk_incr", 32'(o_rbk_incr_ptr), 1);
    chk("call_rbk_cnt",  32'(o_rbk_cnt), 1);
    idle();
    chk("pulse_one_cycle", 32'(o_rbk_en), 0);
    chk("ptr_holds",       32'(o_rbk_ptr), 3);

    // RET killed by RAS flush never becomes valid
    drive(1, 0, 1, 5, 0, 1, 0, 0); cycle();
    chk("killed_ret_du", 32'(o_is_ret_taken_du), 0);
    idle();
    flush();
    chk("killed_no_rbk", 32'(o_rbk_en), 0);
    chk("killed_cnt",    32'(o_rbk_cnt), 1);

    // Stall holds DU and EX; stall + flush still clears
    drive(1, 1, 0, 1, 1, 0, 0, 0); cycle();
    drive(1, 1, 0, 4, 0, 0, 0, 0); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 7, 1, 0, 1, 0); cycle();
      chk("stall_call_du", 32'(o_is_call_du), 1);
    end
    drive(1, 0, 1, 7, 1, 1, 1, 1); cycle();
    chk("stall_flush_en",   32'(o_rbk_en), 1);
    chk("stall_flush_ptr",  32'(o_rbk_ptr), 1);
    chk("stall_flush_full", 32'(o_rbk_full), 1);
    chk("stall_flush_du",   32'(o_is_call_du), 0);
    flush();
    chk("cleared_no_rbk", 32'(o_rbk_en), 0);

    // Back-to-back rollbacks with EX ptr 6 then 2
    drive(1, 0, 1, 6, 0, 0, 0, 0); cycle();
    idle();
    flush();
    chk("rbk6_ptr",  32'(o_rbk_ptr), 6);
    chk("rbk6_incr", 32'(o_rbk_incr_ptr), 0);
    drive(1, 1, 0, 2, 0, 0, 0, 0); cycle();
    idle();
    flush();
    chk("rbk2_ptr", 32'(o_rbk_ptr), 2);
    chk("rbk2_cnt", 32'(o_rbk_cnt), 4);

    // Counter saturation from 16'hFFFE
    force dut.r_rbk_cnt = 16'hFFFE;
    #1;
    release dut.r_rbk_cnt;
    m_cnt = 65534;
    for (int i = 0; i < 3; i++) begin
      drive(1, i[0], 0, i + 1, 0, 0, 0, 0); cycle();
      idle();
      flush();
      chk("sat_cnt_step", 32'(o_rbk_cnt), 32'hFFFF);
    end

    // Reset while a rollback pulse is high
    drive(1, 1, 0, 5, 1, 0, 0, 0); cycle();
    idle();
    flush();
    chk("pre_rst_en", 32'(o_rbk_en), 1);
    aresetn = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_en",   32'(o_rbk_en), 0);
    chk("mid_rst_ptr",  32'(o_rbk_ptr), 0);
    chk("mid_rst_full", 32'(o_rbk_full), 0);
    chk("mid_rst_incr", 32'(o_rbk_incr_ptr), 0);
    chk("mid_rst_cnt",  32'(o_rbk_cnt), 0);
    @(negedge clk);
    aresetn = 1'b1;
    flush();
    chk("post_rst_en", 32'(o_rbk_en), 0);
    flush();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
